// File: rtl/mem_ctrl_pkg.sv
// Shared FSM states, channel ids and ready-channel codes
// for the block memory controller.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSY_W,
        S_BUSY_D,
        S_BUSY_I,
        S_DONE,
        S_HOLD
    } state_t;

    typedef enum logic [1:0] {
        CH_W,
        CH_D,
        CH_I,
        CH_NONE
    } ch_t;

    localparam logic [1:0] READY_IDLE = 2'b00;
    localparam logic [1:0] READY_BUSY = 2'b10;
    localparam logic [1:0] READY_DONE = 2'b01;

    // Done lasts one cycle, then the channel drops back to idle.
    function automatic logic [1:0] next_rdy(
        input logic [1:0] cur,
        input logic       acc,
        input logic       fin
    );
        if (acc) return READY_BUSY;
        if (fin) return READY_DONE;
        if (cur == READY_DONE) return READY_IDLE;
        return cur;
    endfunction

endpackage

// File: rtl/mem_block_array.sv
// Single-ported block store: one 4-word write or read per access,
// with separate held read registers for the I and D destinations.
module mem_block_array
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int MEM_WORDS = 1024,
    parameter int BLK_W     = $clog2(MEM_WORDS / 4)
) (
    input  logic                   Clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    input  logic                   i_we,
    input  logic                   i_dst_i,
    input  logic [BLK_W-1:0]       i_base,
    input  logic [3:0][DATA_W-1:0] i_wdata,
    output logic [3:0][DATA_W-1:0] o_blk_i,
    output logic [3:0][DATA_W-1:0] o_blk_d
);

    logic [DATA_W-1:0]       r_mem [MEM_WORDS];
    logic [3:0][DATA_W-1:0]  r_blk_i;
    logic [3:0][DATA_W-1:0]  r_blk_d;

    always_ff @(posedge Clk) begin
        if (i_en && i_we) begin
            for (int k = 0; k < 4; k++) begin
                r_mem[{i_base, 2'(k)}] <= i_wdata[k];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!i_rst_n) begin
            r_blk_i <= '0;
            r_blk_d <= '0;
        end else if (i_en && !i_we) begin
            for (int k = 0; k < 4; k++) begin
                if (i_dst_i) r_blk_i[k] <= r_mem[{i_base, 2'(k)}];
                else         r_blk_d[k] <= r_mem[{i_base, 2'(k)}];
            end
        end
    end

    assign o_blk_i = r_blk_i;
    assign o_blk_d = r_blk_d;

endmodule

// File: rtl/block_mem_ctrl.sv
// Block memory controller: W > D > I arbitration, fixed latency, 2-bit ready.
// Optional MEM_STATS_EN builds read/writeback completion counters.
module block_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 4
) (
    input  logic              Clk,
    input  logic              Reset_N,
    input  logic              readM1,
    input  logic [ADDR_W-1:0] address1,
    input  logic              readM2,
    input  logic [ADDR_W-1:0] address2,
    input  logic              writeM2,
    input  logic [ADDR_W-1:0] wr_address,
    input  logic [DATA_W-1:0] wr_data00,
    input  logic [DATA_W-1:0] wr_data01,
    input  logic [DATA_W-1:0] wr_data10,
    input  logic [DATA_W-1:0] wr_data11,
    output logic [DATA_W-1:0] instData00,
    output logic [DATA_W-1:0] instData01,
    output logic [DATA_W-1:0] instData10,
    output logic [DATA_W-1:0] instData11,
    output logic [DATA_W-1:0] memData00,
    output logic [DATA_W-1:0] memData01,
    output logic [DATA_W-1:0] memData10,
    output logic [DATA_W-1:0] memData11,
    output logic [1:0]        instReady,
    output logic [1:0]        memReadReady,
    output logic [1:0]        memWriteReady,
    output logic [15:0]       stat_reads,
    output logic [15:0]       stat_writes
);

    localparam int BLK_W = $clog2(MEM_WORDS / 4);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t                 r_state, w_next;
    ch_t                    r_ch, w_pick;
    logic [CNT_W-1:0]       r_cnt;
    logic [BLK_W-1:0]       r_base;
    logic [3:0][DATA_W-1:0] r_wdata, w_blk_i, w_blk_d;
    logic [1:0]             r_rdy_w, r_rdy_d, r_rdy_i;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic                   w_busy, w_fin, w_hold;
    logic                   w_unused;

    assign w_busy = (r_state == S_BUSY_W) || (r_state == S_BUSY_D)
                 || (r_state == S_BUSY_I);
    assign w_fin  = w_busy && (r_cnt == '0);
    assign w_hold = (r_state == S_HOLD);
    assign w_unused = ^w_sel_addr;

    always_ff @(posedge Clk) begin
        if (!Reset_N) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // HOLD still arbitrates, but masks the channel that just finished.
    always_comb begin
        w_next     = r_state;
        w_pick     = CH_NONE;
        w_sel_addr = wr_address;
        case (r_state)
            S_IDLE, S_HOLD: begin
                if (writeM2 && !(w_hold && r_ch == CH_W))     w_pick = CH_W;
                else if (readM2 && !(w_hold && r_ch == CH_D)) w_pick = CH_D;
                else if (readM1 && !(w_hold && r_ch == CH_I)) w_pick = CH_I;
                case (w_pick)
                    CH_W: w_next = S_BUSY_W;
                    CH_D: begin
                        w_next     = S_BUSY_D;
                        w_sel_addr = address2;
                    end
                    CH_I: begin
                        w_next     = S_BUSY_I;
                        w_sel_addr = address1;
                    end
                    default: w_next = S_IDLE;
                endcase
            end
            S_BUSY_W, S_BUSY_D, S_BUSY_I: begin
                if (r_cnt == '0) w_next = S_DONE;
            end
            S_DONE:  w_next = S_HOLD;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            r_ch    <= CH_NONE;
            r_cnt   <= '0;
            r_base  <= '0;
            r_wdata <= '0;
            r_rdy_w <= READY_IDLE;
            r_rdy_d <= READY_IDLE;
            r_rdy_i <= READY_IDLE;
        end else begin
            r_rdy_w <= next_rdy(r_rdy_w, w_pick == CH_W, w_fin && r_ch == CH_W);
            r_rdy_d <= next_rdy(r_rdy_d, w_pick == CH_D, w_fin && r_ch == CH_D);
            r_rdy_i <= next_rdy(r_rdy_i, w_pick == CH_I, w_fin && r_ch == CH_I);
            if (w_pick != CH_NONE) begin
                r_ch   <= w_pick;
                r_cnt  <= CNT_W'(LATENCY - 1);
                r_base <= w_sel_addr[BLK_W+1:2];
                if (w_pick == CH_W) begin
                    r_wdata <= {wr_data11, wr_data10, wr_data01, wr_data00};
                end
            end else if (w_busy && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    mem_block_array #(
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS)
    ) u_array (
        .Clk     (Clk),
        .i_rst_n (Reset_N),
        .i_en    (w_fin && Reset_N),
        .i_we    (r_ch == CH_W),
        .i_dst_i (r_ch == CH_I),
        .i_base  (r_base),
        .i_wdata (r_wdata),
        .o_blk_i (w_blk_i),
        .o_blk_d (w_blk_d)
    );

`ifdef MEM_STATS_EN
    logic [15:0] r_stat_rd, r_stat_wr;

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            r_stat_rd <= '0;
            r_stat_wr <= '0;
        end else if (w_fin) begin
            if (r_ch == CH_W) r_stat_wr <= r_stat_wr + 16'd1;
            else              r_stat_rd <= r_stat_rd + 16'd1;
        end
    end

    assign stat_reads  = r_stat_rd;
    assign stat_writes = r_stat_wr;
`else
    assign stat_reads  = '0;
    assign stat_writes = '0;
`endif

    assign instData00    = w_blk_i[0];
    assign instData01    = w_blk_i[1];
    assign instData10    = w_blk_i[2];
    assign instData11    = w_blk_i[3];
    assign memData00     = w_blk_d[0];
    assign memData01     = w_blk_d[1];
    assign memData10     = w_blk_d[2];
    assign memData11     = w_blk_d[3];
    assign instReady     = r_rdy_i;
    assign memReadReady  = r_rdy_d;
    assign memWriteReady = r_rdy_w;

endmodule

// File: tb/tb_block_mem_ctrl.sv
// Bench for block_mem_ctrl: transaction-level timeline model,
// directed scenarios with literal expectations, then random traffic.
module tb_block_mem_ctrl;

    localparam int LAT = 4;
    localparam int MW  = 1024;
    localparam int NB  = MW / 4;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset_N, readM1, readM2, writeM2;
    logic [15:0] address1, address2, wr_address;
    logic [15:0] wr_data00, wr_data01, wr_data10, wr_data11;
    logic [15:0] instData00, instData01, instData10, instData11;
    logic [15:0] memData00, memData01, memData10, memData11;
    logic [1:0]  instReady, memReadReady, memWriteReady;
    logic [15:0] stat_reads, stat_writes;

    block_mem_ctrl #(
        .ADDR_W(16), .DATA_W(16), .MEM_WORDS(MW), .LATENCY(LAT)
    ) dut (
        .Clk(Clk), .Reset_N(Reset_N),
        .readM1(readM1), .address1(address1),
        .readM2(readM2), .address2(address2),
        .writeM2(writeM2), .wr_address(wr_address),
        .wr_data00(wr_data00), .wr_data01(wr_data01),
        .wr_data10(wr_data10), .wr_data11(wr_data11),
        .instData00(instData00), .instData01(instData01),
        .instData10(instData10), .instData11(instData11),
        .memData00(memData00), .memData01(memData01),
        .memData10(memData10), .memData11(memData11),
        .instReady(instReady), .memReadReady(memReadReady),
        .memWriteReady(memWriteReady),
        .stat_reads(stat_reads), .stat_writes(stat_writes)
    );

    int nrun = 0;
    int nfail = 0;

    // channel index: 0 = writeback, 1 = D read, 2 = I read
    bit   req[3];
    int   hold_n[3];
    int   pd[3];
    int   k = 0;
    bit   act = 0;
    int   ach, acc_k;
    int   next_ok = 0;
    int   excl = -1;
    int   last_done[3] = '{-1, -1, -1};
    int   cap_base;
    logic [15:0] cap_wd[4];
    logic [1:0]  e_rdy[3];
    logic [15:0] e_inst[4], e_mem[4];
    logic [15:0] mm[MW];
    logic [15:0] n_rd = 0, n_wr = 0;
    logic [7:0]  blks[8] = '{8'd4, 8'd16, 8'd32, 8'd1, 8'd2, 8'd99, 8'd200, 8'd255};

    function automatic int blk_of(logic [15:0] a);
        return (int'(a) / 4) % NB;
    endfunction

    function automatic logic [15:0] gen_addr();
        logic [7:0] b;
        b = blks[$urandom_range(7)];
        return {6'($urandom), b, 2'($urandom)};
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        nrun++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, got, want, k);
        end
    endtask

    task automatic drive();
        writeM2 = req[0];
        readM2  = req[1];
        readM1  = req[2];
    endtask

    task automatic model_step();
        bit pins[3];
        bit took;
        pins = '{writeM2, readM2, readM1};
        k++;
        for (int c = 0; c < 3; c++) e_rdy[c] = 2'b00;
        if (!Reset_N) begin
            act = 0;
            for (int j = 0; j < 4; j++) begin
                e_inst[j] = '0;
                e_mem[j]  = '0;
            end
            n_rd = 0;
            n_wr = 0;
            next_ok = k + 1;
            excl = -1;
        end else if (act) begin
            if (k == acc_k + LAT) begin
                e_rdy[ach] = 2'b01;
                act = 0;
                next_ok = k + 2;
                excl = ach;
                last_done[ach] = k;
                for (int j = 0; j < 4; j++) begin
                    if (ach == 0)      mm[cap_base * 4 + j] = cap_wd[j];
                    else if (ach == 1) e_mem[j]  = mm[cap_base * 4 + j];
                    else               e_inst[j] = mm[cap_base * 4 + j];
                end
                if (ach == 0) n_wr++;
                else          n_rd++;
            end else begin
                e_rdy[ach] = 2'b10;
            end
        end else if (k >= next_ok) begin
            took = 0;
            for (int c = 0; c < 3; c++) begin
                if (!took && pins[c] && !(k == next_ok && c == excl)) begin
                    took = 1;
                    act = 1;
                    ach = c;
                    acc_k = k;
                    e_rdy[c] = 2'b10;
                    if (c == 0) begin
                        cap_base = blk_of(wr_address);
                        cap_wd = '{wr_data00, wr_data01, wr_data10, wr_data11};
                    end else if (c == 1) begin
                        cap_base = blk_of(address2);
                    end else begin
                        cap_base = blk_of(address1);
                    end
                end
            end
        end
    endtask

    task automatic compare();
        chk("memWriteReady", 64'(memWriteReady), 64'(e_rdy[0]));
        chk("memReadReady", 64'(memReadReady), 64'(e_rdy[1]));
        chk("instReady", 64'(instReady), 64'(e_rdy[2]));
        chk("instData", {instData11, instData10, instData01, instData00},
            {e_inst[3], e_inst[2], e_inst[1], e_inst[0]});
        chk("memData", {memData11, memData10, memData01, memData00},
            {e_mem[3], e_mem[2], e_mem[1], e_mem[0]});
`ifdef MEM_STATS_EN
        chk("stat_reads", 64'(stat_reads), 64'(n_rd));
        chk("stat_writes", 64'(stat_writes), 64'(n_wr));
`else
        chk("stat_reads_off", 64'(stat_reads), 64'd0);
        chk("stat_writes_off", 64'(stat_writes), 64'd0);
`endif
    endtask

    // Cache-like requester: drop on done, or keep it up 1-2 more cycles.
    task automatic requester();
        for (int c = 0; c < 3; c++) begin
            if (pd[c] > 0) begin
                pd[c]--;
                if (pd[c] == 0) req[c] = 0;
            end else if (req[c] && e_rdy[c] == 2'b01) begin
                pd[c] = hold_n[c];
                if (pd[c] == 0) req[c] = 0;
            end
        end
        drive();
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
        compare();
        requester();
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic wait_done(int c, int maxc);
        int t0, n;
        t0 = last_done[c];
        n = 0;
        while (last_done[c] == t0 && n < maxc) begin
            tick();
            n++;
        end
        nrun++;
        if (last_done[c] == t0) begin
            nfail++;
            $display("FAIL timeout ch%0d: no done within %0d cycles", c, maxc);
        end
    endtask

    task automatic do_write(logic [15:0] a, logic [15:0] d0, logic [15:0] d1,
                            logic [15:0] d2, logic [15:0] d3);
        wr_address = a;
        {wr_data00, wr_data01, wr_data10, wr_data11} = {d0, d1, d2, d3};
        req[0] = 1;
        drive();
        wait_done(0, 40);
    endtask

    task automatic do_read(int c, logic [15:0] a);
        if (c == 1) address2 = a;
        else        address1 = a;
        req[c] = 1;
        drive();
        wait_done(c, 40);
    endtask

    int t0, busy, dk, kw, kd, ki, n, post;
    int pulses[3];

    initial begin
        Reset_N = 0;
        req = '{0, 0, 0};
        hold_n = '{0, 0, 0};
        pd = '{0, 0, 0};
        address1 = 0; address2 = 0; wr_address = 0;
        wr_data00 = 0; wr_data01 = 0; wr_data10 = 0; wr_data11 = 0;
        drive();
        idle(2);
        chk("reset_instReady", 64'(instReady), 64'd0);
        chk("reset_memData", {memData11, memData10, memData01, memData00}, 64'd0);
        Reset_N = 1;
        idle(1);

        do_write(16'h0010, 16'hA000, 16'hA001, 16'hA002, 16'hA003);
        do_write(16'h0080, 16'h0B00, 16'h0B01, 16'h0B02, 16'h0B03);
        for (int i = 0; i < 8; i++) begin
            if (blks[i] != 8'd4 && blks[i] != 8'd32)
                do_write({6'd0, blks[i], 2'd0}, 16'($urandom), 16'($urandom),
                         16'($urandom), 16'($urandom));
        end

        // I-read from IDLE: four busy cycles, done at acceptance + LAT
        idle(3);
        address1 = 16'h0012;
        req[2] = 1;
        drive();
        t0 = k; busy = 0; dk = -1;
        repeat (20) begin
            tick();
            if (instReady == 2'b10) busy++;
            if (instReady == 2'b01 && dk < 0) dk = k;
        end
        chk("iread_busy_cycles", 64'(busy), 64'd4);
        chk("iread_done_edge", 64'(dk - t0), 64'd5);
        chk("iread_data", {instData11, instData10, instData01, instData00},
            {16'hA003, 16'hA002, 16'hA001, 16'hA000});

        // dirty miss: write and read of the same block together
        idle(3);
        wr_address = 16'h0040;
        address2 = 16'h0040;
        {wr_data00, wr_data01, wr_data10, wr_data11} =
            {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        req[0] = 1; req[1] = 1;
        drive();
        t0 = k; kw = -1; kd = -1;
        repeat (30) begin
            tick();
            if (memWriteReady == 2'b01 && kw < 0) kw = k;
            if (memReadReady == 2'b01 && kd < 0) kd = k;
        end
        chk("dirty_write_done", 64'(kw - t0), 64'd5);
        chk("dirty_read_gap", 64'(kd - kw), 64'd6);
        chk("dirty_read_data", {memData11, memData10, memData01, memData00},
            {16'h4444, 16'h3333, 16'h2222, 16'h1111});

        // three-way contention, with wrapped high address bits
        idle(3);
        wr_address = 16'h0004;
        address2 = 16'hFC40;
        address1 = 16'h8012;
        req = '{1, 1, 1};
        drive();
        kw = -1; kd = -1; ki = -1;
        pulses = '{0, 0, 0};
        repeat (40) begin
            tick();
            if (memWriteReady == 2'b01) begin pulses[0]++; if (kw < 0) kw = k; end
            if (memReadReady == 2'b01) begin pulses[1]++; if (kd < 0) kd = k; end
            if (instReady == 2'b01) begin pulses[2]++; if (ki < 0) ki = k; end
        end
        chk("order_w_then_d", 64'(kd - kw), 64'd6);
        chk("order_d_then_i", 64'(ki - kd), 64'd6);
        chk("single_pulses", {32'(pulses[0]), 16'(pulses[1]), 16'(pulses[2])},
            {32'd1, 16'd1, 16'd1});
        chk("wrap_dread", {memData11, memData10, memData01, memData00},
            {16'h4444, 16'h3333, 16'h2222, 16'h1111});
        chk("wrap_iread", {instData11, instData10, instData01, instData00},
            {16'hA003, 16'hA002, 16'hA001, 16'hA000});

        // request held into HOLD must not start a second transfer
        idle(3);
        hold_n[2] = 2;
        address1 = 16'h0012;
        req[2] = 1;
        drive();
        ki = -1; post = 0; pulses[2] = 0;
        repeat (15) begin
            tick();
            if (ki >= 0 && instReady != 2'b00) post++;
            if (instReady == 2'b01) begin pulses[2]++; if (ki < 0) ki = k; end
        end
        hold_n[2] = 0;
        chk("hold_one_pulse", 64'(pulses[2]), 64'd1);
        chk("hold_no_retrigger", 64'(post), 64'd0);

        // reset two cycles into a write: old block contents survive
        idle(3);
        wr_address = 16'h0080;
        {wr_data00, wr_data01, wr_data10, wr_data11} =
            {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D};
        req[0] = 1;
        drive();
        n = 0;
        while (memWriteReady != 2'b10 && n < 20) begin
            tick();
            n++;
        end
        idle(2);
        Reset_N = 0;
        req = '{0, 0, 0};
        pd = '{0, 0, 0};
        drive();
        tick();
        chk("rst_mid_ready", {memWriteReady, memReadReady, instReady}, 64'd0);
        Reset_N = 1;
        idle(2);
        do_read(1, 16'h0080);
        chk("rst_mid_old_data", {memData11, memData10, memData01, memData00},
            {16'h0B03, 16'h0B02, 16'h0B01, 16'h0B00});

        do_read(2, 16'h0004);
        do_write(16'h0008, 16'h5, 16'h6, 16'h7, 16'h8);
        do_read(1, 16'h0008);
        do_write(16'h0004, 16'h1, 16'h2, 16'h3, 16'h4);
        idle(3);
`ifdef MEM_STATS_EN
        chk("stats_reads", 64'(stat_reads), 64'd3);
        chk("stats_writes", 64'(stat_writes), 64'd2);
`else
        chk("stats_reads_off", 64'(stat_reads), 64'd0);
        chk("stats_writes_off", 64'(stat_writes), 64'd0);
`endif

        // random traffic; addresses and data scramble every cycle
        repeat (4000) begin
            wr_address = gen_addr();
            address1 = gen_addr();
            address2 = gen_addr();
            {wr_data00, wr_data01, wr_data10, wr_data11} =
                {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
            if ($urandom_range(399) == 0) begin
                Reset_N = 0;
                req = '{0, 0, 0};
                pd = '{0, 0, 0};
            end else begin
                Reset_N = 1;
                for (int c = 0; c < 3; c++) begin
                    if (!req[c] && pd[c] == 0 && $urandom_range(3) == 0) begin
                        req[c] = 1;
                        hold_n[c] = $urandom_range(2);
                    end
                end
            end
            drive();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

endmodule
